stopwatch_sequencer: RTL and testbench

Front-end run controller for the 4-digit stopwatch datapath (ms tick counter plus BCD digit chain and 7-seg mux). It conditions four raw push-buttons with a synchroniser, debouncer and edge detector. A 4-state FSM then drives the datapath's run enable, clear, manual-increment and display-hold controls. It replaces the bare start/stop controller and sits between board buttons and the datapath.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_sequencer_if.sv | 25 ++
 rtl/stopwatch_sequencer_btn_debounce.sv | 45 ++++
 rtl/stopwatch_sequencer.sv | 140 ++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, button indices and the default
// debounce length, also used by the datapath bench.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    localparam int BTN_STOP  = 3;
    localparam int BTN_START = 2;
    localparam int BTN_LAP   = 1;
    localparam int BTN_INC   = 0;

    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Button/enable inputs and datapath control outputs of the stopwatch sequencer.
interface stopwatch_sequencer_if;

    logic       en;
    logic       start;
    logic       stop;
    logic       inc;
    logic       lap;
    logic       run;
    logic       clear;
    logic       incr;
    logic       hold;
    logic [1:0] state;

    modport master (
        output en, start, stop, inc, lap,
        input  run, clear, incr, hold, state
    );

    modport slave (
        input  en, start, stop, inc, lap,
        output run, clear, incr, hold, state
    );

endinterface

// File: rtl/stopwatch_sequencer_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on the accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int DB_W            = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] LAST_COUNT = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] count;

    // The level only flips after the synchronised input has disagreed with it for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                count <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                count <= count + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch run controller: conditions four buttons and sequences run/clear/incr/hold.
// Define INC_AUTOREPEAT_EN to auto-repeat incr while inc is held in IDLE or PAUSE.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DB_W            = 20
`ifdef INC_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
`endif
) (
    input logic            clock,
    input logic            reset_n,
    stopwatch_sequencer_if.slave bus
);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] act;
    state_t     state_q;
    state_t     state_d;
    logic       clear_d;
    logic       incr_d;
    logic       rep_fire;

    assign raw = {bus.stop, bus.start, bus.lap, bus.inc};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W)
        ) u_debounce (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (raw[i]),
            .level   (level[i]),
            .press   (press[i])
        );
    end

    assign act = press & level;

    // Per state, presses that mean something are tried in stop > start > lap > inc
    // order and only the first one found is acted on.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        incr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (act[BTN_STOP])       clear_d = 1'b1;
                else if (act[BTN_START]) state_d = RUN;
                else if (act[BTN_INC])   incr_d  = 1'b1;
            end
            RUN: begin
                if (act[BTN_STOP])       state_d = PAUSE;
                else if (act[BTN_LAP])   state_d = LAP;
            end
            LAP: begin
                if (act[BTN_STOP])       state_d = PAUSE;
                else if (act[BTN_LAP])   state_d = RUN;
            end
            PAUSE: begin
                if (act[BTN_STOP]) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end else if (act[BTN_START]) begin
                    state_d = RUN;
                end else if (act[BTN_INC]) begin
                    incr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rep_fire && (state_d == state_q) && !clear_d) incr_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bus.run   <= 1'b0;
            bus.hold  <= 1'b0;
            bus.clear <= 1'b0;
            bus.incr  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus.run   <= is_counting(state_d) && bus.en;
            bus.hold  <= (state_d == LAP);
            bus.clear <= clear_d;
            bus.incr  <= incr_d;
        end
    end

    assign bus.state = state_q;

`ifdef INC_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic             armed;
    logic             repeating;
    logic [REP_W-1:0] rep_count;
    logic             inc_taken;

    assign inc_taken = ((state_q == IDLE) || (state_q == PAUSE)) && act[BTN_INC]
                       && !act[BTN_STOP] && !act[BTN_START];

    assign rep_fire  = armed && level[BTN_INC] && ((state_q == IDLE) || (state_q == PAUSE))
                       && (rep_count == (repeating ? PERIOD_LAST : DELAY_LAST));

    // Arming only on an accepted inc press keeps a button held across a state
    // change from starting a repeat on its own.
    always_ff @(posedge clock) begin
        if (!reset_n || !level[BTN_INC] || (state_d != state_q)) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            rep_count <= '0;
        end else if (inc_taken) begin
            armed     <= 1'b1;
            repeating <= 1'b0;
            rep_count <= '0;
        end else if (armed) begin
            if (rep_fire) begin
                repeating <= 1'b1;
                rep_count <= '0;
            end else begin
                rep_count <= rep_count + REP_W'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Self-checking bench for stopwatch_sequencer with a 4-cycle debounce window.
// Build with INC_AUTOREPEAT_EN defined to check the inc auto-repeat timing.
module tb_stopwatch_sequencer;
    import stopwatch_pkg::*;

    localparam int DEBOUNCE      = 4;
    localparam int DBW           = 3;
    localparam int REP_DELAY     = 20;
    localparam int REP_PERIOD    = 8;
    localparam int HOLD_CYCLES   = 10;
    localparam int SETTLE_CYCLES = 30;
    localparam int AR_HOLD       = 60;
    localparam int NUM_VECS      = 23;

    typedef struct packed {
        logic [3:0] btn;
        logic [1:0] exp_state;
        logic       exp_run;
        logic       exp_hold;
        logic       exp_clear;
        logic       exp_incr;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   latency = 0;
    vec_t vectors [NUM_VECS];
    vec_t sb_queue [$];
    int   exp_times [$];

    stopwatch_sequencer_if bus ();

    stopwatch_sequencer #(
        .DEBOUNCE_CYCLES (DEBOUNCE),
        .DB_W            (DBW)
`ifdef INC_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REP_DELAY),
        .REPEAT_PERIOD   (REP_PERIOD)
`endif
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string what, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
        end
    endtask

    task automatic drive_buttons(input logic [3:0] b);
        bus.stop  = b[3];
        bus.start = b[2];
        bus.lap   = b[1];
        bus.inc   = b[0];
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    endtask

    // Press the buttons of one vector, hold, release, and compare at the measured latency.
    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [1:0] prev_state;
        int         clears;
        int         incrs;
        vec_t       exp;
        exp = '0;
        @(negedge clock);
        prev_state = bus.state;
        drive_buttons(v.btn);
        sb_queue.push_back(v);
        clears = 0;
        incrs  = 0;
        for (int c = 1; c <= SETTLE_CYCLES; c++) begin
            @(negedge clock);
            if (bus.clear === 1'b1) clears++;
            if (bus.incr === 1'b1) incrs++;
            if (c == HOLD_CYCLES) drive_buttons(4'b0000);
            if (c == latency - 1)
                check_output($sformatf("vec%0d state before latency", idx), bus.state, prev_state);
            if (c == latency) begin
                exp = sb_queue.pop_front();
                check_output($sformatf("vec%0d state", idx), bus.state, exp.exp_state);
                check_output($sformatf("vec%0d run", idx), bus.run, exp.exp_run);
                check_output($sformatf("vec%0d hold", idx), bus.hold, exp.exp_hold);
                check_output($sformatf("vec%0d clear", idx), bus.clear, exp.exp_clear);
                check_output($sformatf("vec%0d incr", idx), bus.incr, exp.exp_incr);
            end
        end
        check_output($sformatf("vec%0d clear pulses", idx), clears, exp.exp_clear);
        check_output($sformatf("vec%0d incr pulses", idx), incrs, exp.exp_incr);
    endtask

    initial begin
        int clears;
        int incrs;
        int off;
        int accepted;

        // btn = {stop, start, lap, inc}; the table starts in RUN after the latency probe
        vectors[0]  = '{4'b0010, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[1]  = '{4'b0010, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[2]  = '{4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[3]  = '{4'b1000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vectors[4]  = '{4'b1100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vectors[5]  = '{4'b0100, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[6]  = '{4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[7]  = '{4'b0011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[8]  = '{4'b0001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[9]  = '{4'b0101, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[10] = '{4'b0010, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[11] = '{4'b0001, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[12] = '{4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[13] = '{4'b0100, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[14] = '{4'b0001, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[15] = '{4'b0100, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[16] = '{4'b0110, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[17] = '{4'b0100, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[18] = '{4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[19] = '{4'b1000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vectors[20] = '{4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[21] = '{4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[22] = '{4'b1000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};

        reset_n = 1'b0;
        bus.en  = 1'b1;
        drive_buttons(4'b0000);
        repeat (3) @(negedge clock);
        check_output("reset state", bus.state, 2'b00);
        check_output("reset run", bus.run, 1'b0);
        check_output("reset hold", bus.hold, 1'b0);
        check_output("reset clear", bus.clear, 1'b0);
        check_output("reset incr", bus.incr, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Latency probe: first start press from IDLE
        bus.start = 1'b1;
        clears = 0;
        incrs  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == HOLD_CYCLES) bus.start = 1'b0;
            if (bus.clear === 1'b1) clears++;
            if (bus.incr === 1'b1) incrs++;
            if (latency == 0 && bus.state == 2'b01) begin
                latency = c;
                check_output("start run", bus.run, 1'b1);
                check_output("start hold", bus.hold, 1'b0);
            end
        end
        check_output("start accepted", latency != 0, 1'b1);
        if (latency == 0) begin
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $fatal(1, "[TB] aborting: start press never accepted");
        end
        check_output("latency range", (latency >= DEBOUNCE + 2) && (latency <= DEBOUNCE + 4), 1'b1);
        check_output("start clear pulses", clears, 0);
        check_output("start incr pulses", incrs, 0);

        for (int i = 0; i < NUM_VECS; i++) apply_stimulus(vectors[i], i);

        // Held inc in IDLE: pulse at press, then repeat schedule while held
        exp_times.push_back(latency);
`ifdef INC_AUTOREPEAT_EN
        off = REP_DELAY;
        while (off < AR_HOLD) begin
            exp_times.push_back(latency + off);
            off += REP_PERIOD;
        end
`else
        off = 0;
`endif
        @(negedge clock);
        bus.inc = 1'b1;
        for (int c = 1; c <= AR_HOLD + 40; c++) begin
            @(negedge clock);
            if (c == AR_HOLD) bus.inc = 1'b0;
            if (bus.incr === 1'b1)
                check_output("held inc pulse cycle", c, (exp_times.size() != 0) ? exp_times.pop_front() : -1);
        end
        check_output("held inc missing pulses", exp_times.size(), 0);
        check_output("held inc state", bus.state, 2'b00);

        // Bounce 1-0-1 at 2-cycle intervals, then stable high
        @(negedge clock);
        bus.start = 1'b1;
        repeat (2) @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        bus.start = 1'b1;
        for (int c = 1; c <= SETTLE_CYCLES; c++) begin
            @(negedge clock);
            if (c == HOLD_CYCLES) bus.start = 1'b0;
            if (c == latency - 1) check_output("bounce no early press", bus.state, 2'b00);
            if (c == latency) begin
                check_output("bounce press state", bus.state, 2'b01);
                check_output("bounce press run", bus.run, 1'b1);
            end
        end

        // en low freezes run without touching state
        @(negedge clock);
        bus.en = 1'b0;
        @(negedge clock);
        check_output("en low run", bus.run, 1'b0);
        check_output("en low state", bus.state, 2'b01);
        repeat (3) @(negedge clock);
        check_output("en low run later", bus.run, 1'b0);
        check_output("en low state later", bus.state, 2'b01);
        bus.en = 1'b1;
        @(negedge clock);
        check_output("en high run", bus.run, 1'b1);

        // start held through reset is accepted once after release
        reset_n = 1'b0;
        bus.start = 1'b1;
        repeat (3) @(negedge clock);
        check_output("held reset state", bus.state, 2'b00);
        check_output("held reset run", bus.run, 1'b0);
        reset_n = 1'b1;
        accepted = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 20) bus.start = 1'b0;
            if (accepted == 0 && bus.state == 2'b01) accepted = c;
        end
        check_output("held reset accept cycle", accepted, latency);
        check_output("held reset final state", bus.state, 2'b01);

        finish_run();
    end

endmodule
